// File: rtl/pixel_readout_ctrl.sv
// Pixel array sequencer: erase, expose, ramp convert with a gray counter,
// then row-by-row readout with a valid/ready output word stream.
module pixel_readout_ctrl #(
   parameter int ROWS      = 2,
   parameter int DATA_W    = 8,
   parameter int C_ERASE   = 5,
   parameter int C_EXPOSE  = 255,
   parameter int C_CONVERT = 255,
   parameter int C_READ    = 5,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   input  logic [15:0]       exp_cycles,
   input  logic [DATA_W-1:0] pix_bus,
   input  logic              out_ready,
   output logic              erase,
   output logic              expose,
   output logic              convert,
   output logic [ROWS-1:0]   read,
   output logic [DATA_W-1:0] gray_cnt,
   output logic [DATA_W-1:0] out_data,
   output logic [RW-1:0]     out_row,
   output logic              out_valid,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_EXPOSE,
      S_CONVERT,
      S_READ
   } state_t;

   state_t state, state_nxt;

   logic [15:0]       cnt;
   logic [15:0]       cnt_last;
   logic [15:0]       exp_lat;
   logic [RW-1:0]     row;
   logic [DATA_W-1:0] bin;
   logic              phase_done;
   logic              last_row;
   logic              hs;
   logic              capture;

   always_comb begin
      cnt_last = 16'd0;
      unique case (state)
         S_ERASE:   cnt_last = 16'(C_ERASE - 1);
         S_EXPOSE:  cnt_last = (exp_lat != 16'd0) ? exp_lat - 16'd1
                                                  : 16'(C_EXPOSE - 1);
         S_CONVERT: cnt_last = 16'(C_CONVERT - 1);
         S_READ:    cnt_last = 16'(C_READ - 1);
         default:   cnt_last = 16'd0;
      endcase
   end

   assign phase_done = (cnt == cnt_last);
   assign last_row   = (row == RW'(ROWS - 1));
   assign hs         = (state == S_READ) && out_valid && out_ready;
   assign capture    = (state == S_READ) && !out_valid && phase_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (start)      state_nxt = S_ERASE;
         S_ERASE:   if (phase_done) state_nxt = S_EXPOSE;
         S_EXPOSE:  if (phase_done) state_nxt = S_CONVERT;
         S_CONVERT: if (phase_done) state_nxt = S_READ;
         S_READ: begin
            if (hs && last_row)
               state_nxt = continuous ? S_ERASE : S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      erase      = (state == S_ERASE);
      expose     = (state == S_EXPOSE);
      convert    = (state == S_CONVERT);
      read       = '0;
      if (state == S_READ) read = ROWS'(1) << row;
      busy       = (state != S_IDLE);
      frame_done = hs && last_row;
   end

   // The settle counter freezes while a captured word waits for out_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         exp_lat   <= '0;
         row       <= '0;
         bin       <= '0;
         gray_cnt  <= '0;
         out_data  <= '0;
         out_row   <= '0;
         out_valid <= 1'b0;
      end else begin
         gray_cnt <= bin ^ (bin >> 1);

         if (state_nxt != state)
            cnt <= '0;
         else if (hs)
            cnt <= '0;
         else if (state != S_IDLE && !(state == S_READ && out_valid))
            cnt <= cnt + 16'd1;

         if (state_nxt == S_ERASE && state != S_ERASE) begin
            exp_lat <= exp_cycles;
            bin     <= '0;
         end else if (state == S_CONVERT) begin
            bin <= bin + DATA_W'(1);
         end

         if (state_nxt == S_READ && state != S_READ)
            row <= '0;
         else if (hs && !last_row)
            row <= row + RW'(1);

         if (capture) begin
            out_data  <= pix_bus;
            out_row   <= row;
            out_valid <= 1'b1;
         end else if (hs) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl: default frame, exposure override,
// backpressure, continuous mode, reset mid-frame and a 4-bit gray wrap.
module tb_pixel_readout_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, continuous, out_ready;
   logic [15:0] exp_cycles;
   logic [7:0]  pix_bus;
   logic        erase, expose, convert;
   logic [1:0]  read;
   logic [7:0]  gray_cnt, out_data;
   logic        out_row, out_valid, busy, frame_done;

   logic        start4, cont4, ready4;
   logic [15:0] exp4;
   logic [3:0]  pix4;
   logic        erase4, expose4, convert4;
   logic [0:0]  read4;
   logic [3:0]  gray4, data4;
   logic        row4, valid4, busy4, fd4;

   pixel_readout_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .continuous(continuous), .exp_cycles(exp_cycles),
      .pix_bus(pix_bus), .out_ready(out_ready),
      .erase(erase), .expose(expose), .convert(convert),
      .read(read), .gray_cnt(gray_cnt), .out_data(out_data),
      .out_row(out_row), .out_valid(out_valid), .busy(busy),
      .frame_done(frame_done)
   );

   pixel_readout_ctrl #(
      .ROWS(1), .DATA_W(4), .C_ERASE(2), .C_EXPOSE(3),
      .C_CONVERT(20), .C_READ(2)
   ) dut4 (
      .clk(clk), .reset(reset), .start(start4),
      .continuous(cont4), .exp_cycles(exp4),
      .pix_bus(pix4), .out_ready(ready4),
      .erase(erase4), .expose(expose4), .convert(convert4),
      .read(read4), .gray_cnt(gray4), .out_data(data4),
      .out_row(row4), .out_valid(valid4), .busy(busy4),
      .frame_done(fd4)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] g4(input int v);
      logic [3:0] b;
      b = v[3:0];
      return b ^ (b >> 1);
   endfunction

   int         n_er, n_ex, n_cv, n_s0, n_s1, n_w, n_fd;
   logic [7:0] w_data [2];
   int         w_row [2];
   bit         stall_ok, post_erase, post_busy, post_fd;

   task automatic run_frame(input bit do_start, input int stall,
                            input int exp_mid);
      int         left;
      bit         stalling, timed_out;
      logic [7:0] hd;
      n_er = 0; n_ex = 0; n_cv = 0; n_s0 = 0; n_s1 = 0;
      n_w = 0; n_fd = 0;
      w_data[0] = '0; w_data[1] = '0; w_row[0] = -1; w_row[1] = -1;
      left = stall; stalling = 0; stall_ok = 1; timed_out = 1; hd = '0;
      if (do_start) begin
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
      end
      for (int c = 0; c < 3000; c++) begin
         pix_bus = read[1] ? 8'hB2 : 8'hA1;
         if (c == 2 && exp_mid >= 0) exp_cycles = 16'(exp_mid);
         if (erase)   n_er++;
         if (expose)  n_ex++;
         if (convert) n_cv++;
         if (read[0] && !out_valid) n_s0++;
         if (read[1] && !out_valid) n_s1++;
         if (out_valid && out_row == 1'b0 && left > 0 && !stalling) begin
            stalling  = 1;
            out_ready = 1'b0;
            hd        = out_data;
         end else if (stalling) begin
            if (!(out_valid && read == 2'b01 && out_data == hd &&
                  out_row == 1'b0))
               stall_ok = 0;
            left--;
            if (left == 0) begin
               out_ready = 1'b1;
               stalling  = 0;
            end
         end
         if (out_valid && out_ready) begin
            if (n_w < 2) begin
               w_data[n_w] = out_data;
               w_row[n_w]  = int'(out_row);
            end
            n_w++;
         end
         if (frame_done) begin
            n_fd++;
            timed_out = 0;
            break;
         end
         @(negedge clk);
      end
      if (timed_out) check("frame_timeout", 1, 0);
      @(negedge clk);
      post_erase = erase;
      post_busy  = busy;
      post_fd    = frame_done;
   endtask

   task automatic check_words(input string tag);
      check({tag, "_words"}, n_w, 2);
      check({tag, "_row0"}, w_row[0], 0);
      check({tag, "_row1"}, w_row[1], 1);
      check({tag, "_data0"}, w_data[0], 8'hA1);
      check({tag, "_data1"}, w_data[1], 8'hB2);
      check({tag, "_fd"}, n_fd, 1);
   endtask

   task automatic check_zero(input string tag);
      check(tag, {erase, expose, convert, read, gray_cnt, out_data,
                  out_row, out_valid, busy, frame_done}, 0);
   endtask

   initial begin
      int k, mism, n_cv4, n_w4, n_fd4;
      logic [3:0] gk16, gk17, d4;
      bit seen;

      reset = 1'b0; start = 1'b0; continuous = 1'b0; out_ready = 1'b1;
      exp_cycles = '0; pix_bus = '0;
      start4 = 1'b0; cont4 = 1'b0; ready4 = 1'b1; exp4 = '0; pix4 = 4'h9;
      #12;
      check_zero("reset_outs");
      @(negedge clk) reset = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_strobes", {erase, expose, convert, read}, 0);

      run_frame(1, 0, -1);
      check("def_erase", n_er, 5);
      check("def_expose", n_ex, 255);
      check("def_convert", n_cv, 255);
      check("def_settle0", n_s0, 5);
      check("def_settle1", n_s1, 5);
      check_words("def");
      check("def_fd_pulse", post_fd, 0);
      check("def_busy_end", post_busy, 0);

      exp_cycles = 16'd10;
      run_frame(1, 0, 3);
      check("exp10_expose", n_ex, 10);
      check_words("exp10");

      exp_cycles = 16'd2;
      run_frame(1, 20, -1);
      check("stall_stable", stall_ok, 1);
      check("stall_settle0", n_s0, 5);
      check_words("stall");
      check("stall_busy_end", post_busy, 0);

      continuous = 1'b1;
      exp_cycles = 16'd4;
      run_frame(1, 0, 6);
      check("cont_expose1", n_ex, 4);
      check_words("cont1");
      check("cont_next_erase", post_erase, 1);
      check("cont_next_busy", post_busy, 1);
      continuous = 1'b0;
      run_frame(0, 0, -1);
      check("cont_erase2", n_er, 5);
      check("cont_expose2", n_ex, 6);
      check_words("cont2");
      check("cont_idle", {post_busy, post_erase}, 0);

      exp_cycles = 16'd0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      seen = 0;
      for (int c = 0; c < 400; c++) begin
         if (convert) begin seen = 1; break; end
         @(negedge clk);
      end
      check("rst_cv_reached", seen, 1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1 check_zero("rst_in_convert");
      @(negedge clk) reset = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_cv_idle", busy, 0);

      exp_cycles = 16'd2;
      out_ready  = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      seen = 0;
      for (int c = 0; c < 700; c++) begin
         if (out_valid) begin seen = 1; break; end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("rst_rd_pending", {seen, out_valid}, 2'b11);
      #2 reset = 1'b0;
      #1 check_zero("rst_in_read");
      @(negedge clk) reset = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_rd_idle", busy, 0);

      exp_cycles = 16'd0;
      run_frame(1, 0, -1);
      check("post_rst_erase", n_er, 5);
      check("post_rst_expose", n_ex, 255);
      check("post_rst_convert", n_cv, 255);
      check_words("post_rst");
      check("post_rst_busy", post_busy, 0);

      mism = 0; n_cv4 = 0; n_w4 = 0; n_fd4 = 0; k = 0;
      gk16 = 4'hF; gk17 = 4'hF; d4 = '0; seen = 0;
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (convert4) begin
            if (gray4 != ((k == 0) ? 4'd0 : g4((k - 1) % 16))) mism++;
            if (k == 16) gk16 = gray4;
            if (k == 17) gk17 = gray4;
            k++;
            n_cv4++;
         end
         if (valid4 && ready4) begin
            n_w4++;
            d4 = data4;
            if (row4 != 1'b0) mism++;
         end
         if (fd4) begin n_fd4++; seen = 1; break; end
         @(negedge clk);
      end
      check("w4_done", seen, 1);
      check("w4_convert", n_cv4, 20);
      check("w4_gray_seq", mism, 0);
      check("w4_gray_15", gk16, 4'h8);
      check("w4_gray_wrap", gk17, 4'h0);
      check("w4_words", n_w4, 1);
      check("w4_data", d4, 4'h9);
      check("w4_fd", n_fd4, 1);
      @(negedge clk);
      check("w4_gray_final", gray4, 4'h6);
      check("w4_idle", busy4, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pixel_readout_ctrl.md
PIXEL_READOUT_CTRL -- requirements
Module: pixel_readout_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ROWS, 2, pixel rows read per frame, >=1.
- DATA_W, 8, gray counter and pixel data width.
- C_ERASE, 5, erase phase length in cycles, >=1.
- C_EXPOSE, 255, default exposure length in cycles, >=1.
- C_CONVERT, 255, ramp/convert phase length in cycles, >=1.
- C_READ, 5, row settle length in cycles, >=1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- start, in, 1, frame request.
- continuous, in, 1, free-running frame mode.
- exp_cycles, in, 16, exposure override; 0 selects C_EXPOSE.
- pix_bus, in, DATA_W, tri-state pixel bus value from array.
- out_ready, in, 1, downstream accepts word.
- erase, out, 1, pixel erase strobe.
- expose, out, 1, pixel expose strobe.
- convert, out, 1, ramp/compare enable.
- read, out, ROWS, one-hot row read enables.
- gray_cnt, out, DATA_W, gray-coded conversion count.
- out_data, out, DATA_W, captured pixel word.
- out_row, out, clog2(ROWS) (min 1), row index of out_data.
- out_valid, out, 1, out_data valid.
- busy, out, 1, high in any state except IDLE.
- frame_done, out, 1, one-cycle end-of-frame pulse.

Function
REQ-003 FSM states SHALL be IDLE, ERASE, EXPOSE, CONVERT, READ; exactly one of erase/expose/convert/|read is high in its matching state, all low in IDLE.
REQ-004 IDLE->ERASE on clk edge with start=1; exp_cycles is latched on that same edge; start is ignored in all other states.
REQ-005 ERASE SHALL last exactly C_ERASE cycles, then EXPOSE.
REQ-006 EXPOSE SHALL last exactly E cycles, E = latched exp_cycles if nonzero else C_EXPOSE, then CONVERT.
REQ-007 CONVERT SHALL last exactly C_CONVERT cycles; internal binary counter clears to 0 on ERASE entry, increments once per CONVERT cycle, wraps modulo 2^DATA_W, holds outside CONVERT.
REQ-008 gray_cnt SHALL equal bin ^ (bin >> 1), registered, updating the cycle after the binary count.
REQ-009 READ starts at row 0; read[r] high for C_READ settle cycles; on the last settle cycle's edge pix_bus is captured into out_data, out_row<=r, out_valid<=1.
REQ-010 While out_valid=1 and out_ready=0, out_data, out_row, read[r] SHALL hold unchanged (backpressure).
REQ-011 On edge with out_valid=1 and out_ready=1: out_valid<=0; if r<ROWS-1, read moves to r+1 and settle restarts; else frame ends.
REQ-012 Frame end: frame_done high for exactly one cycle; next state ERASE if continuous=1 (exp_cycles re-latched), else IDLE.
REQ-013 out_ready high before out_valid SHALL NOT complete a handshake; no word is ever dropped or duplicated.
REQ-014 ROWS=1: single read per frame, out_row constant 0.

Reset
REQ-015 reset low SHALL immediately force IDLE and all outputs 0 (read=0, gray_cnt=0, out_data=0, out_valid=0, busy=0, frame_done=0), regardless of state, including mid-READ with a pending word.
REQ-016 After reset release, no activity until start sampled high.

Verification
REQ-017 Defaults, exp_cycles=0, out_ready=1, pulse start -> erase 5 cyc, expose 255, convert 255, read[0] 5 cyc, read[1] 5 cyc; out_row 0 then 1; frame_done one pulse; busy back to 0.
REQ-018 exp_cycles=10 at start -> expose exactly 10 cycles; changing exp_cycles mid-frame has no effect.
REQ-019 out_ready=0 for 20 cycles at row 0 word -> out_valid, out_data, read[0] stable 20 cycles; release -> row 1 proceeds, two words total.
REQ-020 DATA_W=4, C_CONVERT=20 -> binary wraps 15->0; gray_cnt sequence 0,1,3,2,...,8,0 and final value gray(4)=6.
REQ-021 continuous=1 -> frame_done then erase the next cycle with no IDLE; drop continuous -> IDLE after current frame.
REQ-022 reset low during CONVERT and during stalled READ -> all outputs 0 same cycle; start after release runs a clean full frame.
